dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter and access sequencer for the single-port synchronous data RAM. It sits between the MEM stage (master 0, "core") and an external debug/DMA master (master 1, "ext"). It grants one RAM access per issue slot, sequences the one-cycle RAM read latency, and tells pipeline control to hold MEM while a core access is pending. The core-side signal set matches what MEM already drives: ce, we, sel, addr and wdata.

## Interface
- WIDTH, 32, data and address width.
- clk  in  1  clock. One clock domain; everything is sampled on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- core_ce  in  1  core access request. Held by MEM until core_stall is low.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  WIDTH  byte address.
- core_sel  in  4  byte-lane write enables.
- core_wdata  in  WIDTH  store data, already lane-replicated by MEM.
- core_rdata  out  WIDTH  load data. Valid in the cycle core_stall falls after a load.
- core_stall  out  1  hold request to ctrl; freezes MEM/WB.
- ext_valid  in  1  ext request valid.
- ext_we, ext_addr, ext_sel, ext_wdata  in  1/WIDTH/4/WIDTH  same meaning as the core_* signals.
- ext_ready  out  1  ext request accepted this cycle.
- ext_rvalid  out  1  ext read data valid; one-cycle pulse.
- ext_rdata  out  WIDTH  ext read data.
- ram_ce, ram_we  out  1  RAM enable and write.
- ram_addr, ram_sel, ram_wdata  out  WIDTH/4/WIDTH  RAM command.
- ram_rdata  in  WIDTH  RAM read data, valid the cycle after ram_ce=1 with ram_we=0.

## Operation
- FSM states: IDLE, CORE_RD, EXT_RD.
- IDLE: pick a winner from {core_ce, ext_valid} and drive the ram_* outputs combinationally from the winner.
  - Winner store: completes in the same cycle, state stays IDLE.
  - Winner load: state goes to CORE_RD or EXT_RD.
- CORE_RD:
  - ram_ce=0.
  - core_rdata=ram_rdata, core_stall=0.
  - Next state IDLE. The core's held request is not reissued.
- EXT_RD:
  - ram_ce=0.
  - ext_rvalid=1, ext_rdata=ram_rdata.
  - Next state IDLE.
- core_stall is 1 in any of these cycles:
  - core_ce=1 and the core is not granted; or
  - the core is granted a load in IDLE; or
  - core_ce=1 while in EXT_RD.
- core_stall is 0 for a granted core store.
- ext_ready is 1 only in an IDLE cycle where ext is granted. An ext request stays pending while ext_valid=1 and ext_ready=0. ext must keep its request fields stable during that time.
- Arbitration when both request:
  - Under the macro in Configuration: round-robin. Register last_gnt; the winner is the master not granted last. last_gnt updates on every grant.
  - Without the macro: fixed priority, core wins.
- ram_sel is passed through from the winner. For loads the RAM returns a full word; lane extraction is done in MEM.
- No combinational path from ram_rdata to any ram_* output.

## Timing
- Store latency: 0 extra cycles (grant cycle = write cycle).
- Load latency: issue in cycle N, data in cycle N+1. Core stalls exactly 1 cycle when uncontended.
- Maximum throughput: one store per cycle; one load per 2 cycles.
- Reset values:
  - state=IDLE, last_gnt=1 (core wins the first contention).
  - All outputs 0: ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, ext_ready, ext_rvalid, ext_rdata, core_rdata, core_stall.
- Reset asserted in CORE_RD or EXT_RD:
  - Next cycle is IDLE.
  - No rvalid pulse and no data delivered.
  - The RAM read is abandoned.
- Simultaneous requests in IDLE: exactly one grant. The loser sees stall=1 or ready=0.
- Core load and ext load back-to-back under round-robin: core issues at N, data at N+1; ext issues at N+2, rvalid at N+3.
- No request while in an RD state can be granted.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration with the last_gnt register.
- Not defined: fixed core-first priority; last_gnt is not implemented. Under continuous core traffic ext may starve; this is accepted for core-only builds.

## Structure
- FSM state encodings (ARB_IDLE, ARB_CORE_RD, ARB_EXT_RD) and grant IDs (GNT_CORE=0, GNT_EXT=1) go in the shared definitions header param_def.v.
- One sub-module: arb_pick2. It is combinational 2-request priority selection that takes last_gnt and produces a one-hot grant; fixed priority when the macro is off.
- The top level holds the FSM, the command mux and the stall/ready/rvalid generation.

## Test plan
- Core SW 0x1000 = 0xDEADBEEF, sel=1111, ext idle -> ram_we=1 in the same cycle, core_stall=0 throughout.
- Core LW 0x1000 after that store -> stall=1 at N, stall=0 and core_rdata=0xDEADBEEF at N+1, exactly 2 cycles total.
- Core and ext both request loads at N, after reset, RR enabled -> core granted at N, ext_ready=1 at N+2, ext_rvalid=1 at N+3.
- ext SB 0x2003 with sel=1000 while core idle -> ext_ready=1 and ram_sel=1000 in the same cycle, no rvalid.
- rst asserted during EXT_RD -> ext_rvalid stays 0, all outputs 0 next cycle, FSM is IDLE.
- Macro off, core_ce held for 10 cycles with ext_valid=1 -> ext_ready stays 0 until core_ce drops, then ext_ready=1 in the next IDLE cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM state codes and grant IDs.
// Pure constants, no logic.
package dmem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_CORE_RD = 2'd1;
    localparam logic [1:0] ARB_EXT_RD  = 2'd2;

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_EXT  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_pick2.sv
// Two-request grant selector producing a one-hot grant; combinational, no backpressure.
// Build option DMEM_ARB_RR_EN: round-robin on last_gnt; otherwise fixed core-first priority.
module arb_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic req_core,
    input  logic req_ext,
`ifdef DMEM_ARB_RR_EN
    input  logic last_gnt,
`endif
    output logic gnt_core,
    output logic gnt_ext
);

    always_comb begin
        gnt_core = 1'b0;
        gnt_ext  = 1'b0;
        if (req_core && req_ext) begin
`ifdef DMEM_ARB_RR_EN
            // The master that was not served last wins the contention.
            if (last_gnt == GNT_EXT) begin
                gnt_core = 1'b1;
            end else begin
                gnt_ext = 1'b1;
            end
`else
            gnt_core = 1'b1;
`endif
        end else begin
            gnt_core = req_core;
            gnt_ext  = req_ext;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/ext arbiter and access sequencer for the single-port data RAM; stores 0 extra cycles, loads 1.
// Core is held via core_stall, ext via ext_ready; build option DMEM_ARB_RR_EN selects round-robin.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_ce,
    input  logic             core_we,
    input  logic [WIDTH-1:0] core_addr,
    input  logic [3:0]       core_sel,
    input  logic [WIDTH-1:0] core_wdata,
    output logic [WIDTH-1:0] core_rdata,
    output logic             core_stall,
    input  logic             ext_valid,
    input  logic             ext_we,
    input  logic [WIDTH-1:0] ext_addr,
    input  logic [3:0]       ext_sel,
    input  logic [WIDTH-1:0] ext_wdata,
    output logic             ext_ready,
    output logic             ext_rvalid,
    output logic [WIDTH-1:0] ext_rdata,
    output logic             ram_ce,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_addr,
    output logic [3:0]       ram_sel,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    logic [1:0] state_q, state_d;
    logic       gnt_core, gnt_ext;
    logic       in_idle;

    assign in_idle = (state_q == ARB_IDLE);

`ifdef DMEM_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt_core) begin
            last_gnt_d = GNT_CORE;
        end else if (gnt_ext) begin
            last_gnt_d = GNT_EXT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= GNT_EXT;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    // Requests only compete in IDLE; anything arriving during a read stays pending.
    arb_pick2 u_pick (
        .req_core (core_ce & in_idle),
        .req_ext  (ext_valid & in_idle),
`ifdef DMEM_ARB_RR_EN
        .last_gnt (last_gnt_q),
`endif
        .gnt_core (gnt_core),
        .gnt_ext  (gnt_ext)
    );

    always_comb begin
        state_d    = state_q;
        ram_ce     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_sel    = '0;
        ram_wdata  = '0;
        ext_ready  = 1'b0;
        ext_rvalid = 1'b0;
        ext_rdata  = '0;
        core_rdata = '0;
        core_stall = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB_IDLE: begin
                    core_stall = core_ce && !(gnt_core && core_we);
                    if (gnt_core) begin
                        ram_ce    = 1'b1;
                        ram_we    = core_we;
                        ram_addr  = core_addr;
                        ram_sel   = core_sel;
                        ram_wdata = core_wdata;
                        if (!core_we) begin
                            state_d = ARB_CORE_RD;
                        end
                    end else if (gnt_ext) begin
                        ram_ce    = 1'b1;
                        ram_we    = ext_we;
                        ram_addr  = ext_addr;
                        ram_sel   = ext_sel;
                        ram_wdata = ext_wdata;
                        ext_ready = 1'b1;
                        if (!ext_we) begin
                            state_d = ARB_EXT_RD;
                        end
                    end
                end
                ARB_CORE_RD: begin
                    // Releasing the stall retires the held core request; it is not reissued.
                    core_rdata = ram_rdata;
                    state_d    = ARB_IDLE;
                end
                ARB_EXT_RD: begin
                    ext_rvalid = 1'b1;
                    ext_rdata  = ram_rdata;
                    core_stall = core_ce;
                    state_d    = ARB_IDLE;
                end
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_ce = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic [3:0]  core_sel = '0;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        ext_valid = 1'b0, ext_we = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic [3:0]  ext_sel = '0;
    logic        ext_ready, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_sel;
    logic [31:0] ram_rdata = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .core_ce(core_ce), .core_we(core_we), .core_addr(core_addr), .core_sel(core_sel),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_sel(ext_sel),
        .ext_wdata(ext_wdata), .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural single-port RAM with byte lanes and one-cycle read latency.
    logic [31:0] mem [0:4095] = '{default: 32'h0};
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                for (int i = 0; i < 4; i++)
                    if (ram_sel[i]) mem[ram_addr[13:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[13:2]];
            end
        end
    end

    task automatic idle_inputs();
        core_ce = 1'b0; core_we = 1'b0; core_addr = '0; core_sel = '0; core_wdata = '0;
        ext_valid = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_sel = '0; ext_wdata = '0;
    endtask

    task automatic reset_cycle();
        @(negedge clk); rst = 1'b1; idle_inputs();
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h1000; core_sel = 4'hF;
        ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 32'h2000; ext_sel = 4'hF; ext_wdata = 32'h1234_5678;
        #1;
        total++; if ({ram_ce, ram_we, ext_ready, ext_rvalid, core_stall} !== 5'b0) begin bad++;
            $display("FAIL rst_ctl got=%b exp=00000", {ram_ce, ram_we, ext_ready, ext_rvalid, core_stall}); end
        total++; if (ram_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", ram_addr); end
        total++; if (ram_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", ram_wdata); end
        total++; if (ram_sel !== 4'h0) begin bad++; $display("FAIL rst_sel got=%h exp=0", ram_sel); end
        total++; if (ext_rdata !== 32'h0) begin bad++; $display("FAIL rst_ext_rdata got=%h exp=0", ext_rdata); end
        total++; if (core_rdata !== 32'h0) begin bad++; $display("FAIL rst_core_rdata got=%h exp=0", core_rdata); end
        @(negedge clk); rst = 1'b0; idle_inputs(); #1;
        total++; if ({ram_ce, core_stall, ext_rvalid} !== 3'b0) begin bad++;
            $display("FAIL post_rst_idle got=%b exp=000", {ram_ce, core_stall, ext_rvalid}); end
    endtask

    task automatic test_core_store();
        @(negedge clk);
        core_ce = 1'b1; core_we = 1'b1; core_addr = 32'h1000; core_sel = 4'hF; core_wdata = 32'hDEAD_BEEF;
        #1;
        total++; if ({ram_ce, ram_we, core_stall} !== 3'b110) begin bad++;
            $display("FAIL sw_ctl got=%b exp=110", {ram_ce, ram_we, core_stall}); end
        total++; if (ram_addr !== 32'h1000 || ram_wdata !== 32'hDEAD_BEEF || ram_sel !== 4'hF) begin bad++;
            $display("FAIL sw_cmd got=%h/%h/%h exp=00001000/deadbeef/f", ram_addr, ram_wdata, ram_sel); end
        @(negedge clk); idle_inputs(); #1;
        total++; if ({ram_ce, core_stall} !== 2'b00) begin bad++;
            $display("FAIL sw_after got=%b exp=00", {ram_ce, core_stall}); end
    endtask

    task automatic test_core_load();
        @(negedge clk);
        core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h1000; core_sel = 4'hF;
        #1;
        total++; if ({ram_ce, ram_we, core_stall} !== 3'b101) begin bad++;
            $display("FAIL lw_issue got=%b exp=101", {ram_ce, ram_we, core_stall}); end
        @(negedge clk); #1;
        total++; if ({ram_ce, core_stall} !== 2'b00) begin bad++;
            $display("FAIL lw_data_ctl got=%b exp=00", {ram_ce, core_stall}); end
        total++; if (core_rdata !== 32'hDEAD_BEEF) begin bad++;
            $display("FAIL lw_data got=%h exp=deadbeef", core_rdata); end
        @(negedge clk); idle_inputs(); #1;
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL lw_after got=%b exp=0", core_stall); end
    endtask

    task automatic test_contention_loads();
        reset_cycle();
        core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h1000; core_sel = 4'hF;
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h1000; ext_sel = 4'hF;
        #1;
        total++; if ({ram_ce, core_stall, ext_ready} !== 3'b110) begin bad++;
            $display("FAIL both_n got=%b exp=110", {ram_ce, core_stall, ext_ready}); end
        @(negedge clk); #1;
        total++; if ({ram_ce, core_stall, ext_ready} !== 3'b000 || core_rdata !== 32'hDEAD_BEEF) begin bad++;
            $display("FAIL both_n1 got=%b/%h exp=000/deadbeef", {ram_ce, core_stall, ext_ready}, core_rdata); end
        @(negedge clk); core_ce = 1'b0; #1;
        total++; if ({ram_ce, ram_we, ext_ready, ext_rvalid} !== 4'b1010) begin bad++;
            $display("FAIL both_n2 got=%b exp=1010", {ram_ce, ram_we, ext_ready, ext_rvalid}); end
        @(negedge clk); ext_valid = 1'b0; #1;
        total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hDEAD_BEEF) begin bad++;
            $display("FAIL both_n3 got=%b/%h exp=1/deadbeef", ext_rvalid, ext_rdata); end
        @(negedge clk); #1;
        total++; if (ext_rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_pulse got=%b exp=0", ext_rvalid); end
        idle_inputs();
    endtask

    task automatic test_ext_byte_store();
        @(negedge clk);
        ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 32'h2003; ext_sel = 4'b1000; ext_wdata = 32'hABAB_ABAB;
        #1;
        total++; if ({ext_ready, ram_ce, ram_we} !== 3'b111 || ram_sel !== 4'b1000 || ram_addr !== 32'h2003) begin bad++;
            $display("FAIL sb_issue got=%b/%b/%h exp=111/1000/00002003", {ext_ready, ram_ce, ram_we}, ram_sel, ram_addr); end
        @(negedge clk); ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h2000; ext_sel = 4'hF; #1;
        total++; if (ext_rvalid !== 1'b0 || ext_ready !== 1'b1) begin bad++;
            $display("FAIL sb_no_rvalid got=%b/%b exp=0/1", ext_rvalid, ext_ready); end
        @(negedge clk); ext_valid = 1'b0; #1;
        total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hAB00_0000) begin bad++;
            $display("FAIL sb_readback got=%b/%h exp=1/ab000000", ext_rvalid, ext_rdata); end
        idle_inputs();
    endtask

    task automatic test_reset_in_ext_rd();
        @(negedge clk);
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h1000; ext_sel = 4'hF;
        #1;
        total++; if (ext_ready !== 1'b1) begin bad++; $display("FAIL rrd_issue got=%b exp=1", ext_ready); end
        @(negedge clk); ext_valid = 1'b0; rst = 1'b1; #1;
        total++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) begin bad++;
            $display("FAIL rrd_abandon got=%b/%h exp=0/0", ext_rvalid, ext_rdata); end
        @(negedge clk); rst = 1'b0; #1;
        total++; if ({ram_ce, ext_rvalid, ext_ready, core_stall} !== 4'b0 || ext_rdata !== 32'h0 || core_rdata !== 32'h0) begin bad++;
            $display("FAIL rrd_after got=%b/%h/%h exp=0000/0/0", {ram_ce, ext_rvalid, ext_ready, core_stall}, ext_rdata, core_rdata); end
        @(negedge clk);
        core_ce = 1'b1; core_we = 1'b1; core_addr = 32'h1004; core_sel = 4'hF; core_wdata = 32'h1;
        #1;
        total++; if ({ram_ce, ram_we, core_stall} !== 3'b110) begin bad++;
            $display("FAIL rrd_idle_grant got=%b exp=110", {ram_ce, ram_we, core_stall}); end
        @(negedge clk); idle_inputs();
    endtask

`ifndef DMEM_ARB_RR_EN
    task automatic test_ext_starve();
        reset_cycle();
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h1000; ext_sel = 4'hF;
        for (int c = 0; c < 10; c++) begin
            core_ce = 1'b1; core_we = 1'b1; core_addr = 32'h1008; core_sel = 4'hF; core_wdata = $urandom;
            #1;
            total++; if (ext_ready !== 1'b0 || core_stall !== 1'b0) begin bad++;
                $display("FAIL starve c=%0d got=%b/%b exp=0/0", c, ext_ready, core_stall); end
            @(negedge clk);
        end
        core_ce = 1'b0; #1;
        total++; if (ext_ready !== 1'b1) begin bad++; $display("FAIL starve_release got=%b exp=1", ext_ready); end
        @(negedge clk); ext_valid = 1'b0; #1;
        total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hDEAD_BEEF) begin bad++;
            $display("FAIL starve_data got=%b/%h exp=1/deadbeef", ext_rvalid, ext_rdata); end
        idle_inputs();
    endtask
`else
    task automatic test_ext_starve();
        reset_cycle();
        ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 32'h1000; ext_sel = 4'hF;
        core_ce = 1'b1; core_we = 1'b1; core_addr = 32'h1008; core_sel = 4'hF; core_wdata = 32'h5;
        #1;
        total++; if ({ext_ready, core_stall} !== 2'b00) begin bad++;
            $display("FAIL rr_c0 got=%b exp=00", {ext_ready, core_stall}); end
        @(negedge clk); core_wdata = 32'h6; #1;
        total++; if ({ext_ready, core_stall} !== 2'b11) begin bad++;
            $display("FAIL rr_c1 got=%b exp=11", {ext_ready, core_stall}); end
        @(negedge clk); ext_valid = 1'b0; #1;
        total++; if ({ext_rvalid, core_stall} !== 2'b11) begin bad++;
            $display("FAIL rr_c2 got=%b exp=11", {ext_rvalid, core_stall}); end
        @(negedge clk); #1;
        total++; if ({ram_ce, core_stall} !== 2'b10) begin bad++;
            $display("FAIL rr_c3 got=%b exp=10", {ram_ce, core_stall}); end
        @(negedge clk); idle_inputs();
    endtask
`endif

    // Randomized traffic: the model tracks which master owns an outstanding read, who won last,
    // and a word image of the 0x3000-0x303F window the random masters touch.
    task automatic test_random();
        logic [31:0] ref_mem [0:15];
        int          owner = 0;        // 0 none, 1 core read pending, 2 ext read pending
        int          last = 2;         // last winner, 1 core, 2 ext
        int          win;
        logic [31:0] rd_data = '0;
        logic        core_done = 1'b0, ext_done = 1'b0;
        logic        e_ce, e_we, e_ready, e_rvalid, e_stall, chk_crd, chk_erd;
        logic [31:0] e_addr, e_wdata, e_crd, e_erd;
        logic [3:0]  e_sel;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        reset_cycle();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (core_done || rst) core_ce = 1'b0;
            if (ext_done || rst) ext_valid = 1'b0;
            rst = ($urandom_range(0, 99) == 0);
            if (!core_ce && $urandom_range(0, 2) != 0) begin
                core_ce = 1'b1; core_we = $urandom_range(0, 1);
                core_addr = 32'h3000 + 4 * $urandom_range(0, 15);
                core_sel = core_we ? 4'($urandom_range(1, 15)) : 4'hF; core_wdata = $urandom;
            end
            if (!ext_valid && $urandom_range(0, 2) != 0) begin
                ext_valid = 1'b1; ext_we = $urandom_range(0, 1);
                ext_addr = 32'h3000 + 4 * $urandom_range(0, 15);
                ext_sel = ext_we ? 4'($urandom_range(1, 15)) : 4'hF; ext_wdata = $urandom;
            end
            #1;
            e_ce = 0; e_we = 0; e_addr = '0; e_sel = '0; e_wdata = '0; e_ready = 0; e_rvalid = 0;
            e_stall = 0; e_crd = '0; e_erd = '0; chk_crd = 0; chk_erd = 0; win = 0;
            if (rst) begin
                chk_crd = 1; chk_erd = 1;
            end else if (owner == 1) begin
                e_crd = rd_data; chk_crd = 1;
            end else if (owner == 2) begin
                e_rvalid = 1; e_erd = rd_data; chk_erd = 1; e_stall = core_ce;
            end else begin
`ifdef DMEM_ARB_RR_EN
                if (core_ce && ext_valid) win = (last == 2) ? 1 : 2;
`else
                if (core_ce && ext_valid) win = 1;
`endif
                else if (core_ce) win = 1;
                else if (ext_valid) win = 2;
                if (win == 1) begin
                    e_ce = 1; e_we = core_we; e_addr = core_addr; e_sel = core_sel; e_wdata = core_wdata;
                end else if (win == 2) begin
                    e_ce = 1; e_we = ext_we; e_addr = ext_addr; e_sel = ext_sel; e_wdata = ext_wdata; e_ready = 1;
                end
                e_stall = core_ce && !(win == 1 && core_we);
            end
            total++; if (ram_ce !== e_ce) begin bad++; $display("FAIL rnd_ce cyc=%0d got=%b exp=%b", cyc, ram_ce, e_ce); end
            total++; if (ext_ready !== e_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, ext_ready, e_ready); end
            total++; if (ext_rvalid !== e_rvalid) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, ext_rvalid, e_rvalid); end
            total++; if (core_stall !== e_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, core_stall, e_stall); end
            if (e_ce) begin
                total++; if (ram_we !== e_we || ram_addr !== e_addr || ram_sel !== e_sel) begin bad++;
                    $display("FAIL rnd_cmd cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, ram_we, ram_addr, ram_sel, e_we, e_addr, e_sel); end
                if (e_we) begin
                    total++; if (ram_wdata !== e_wdata) begin bad++;
                        $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, ram_wdata, e_wdata); end
                end
            end
            if (chk_crd) begin
                total++; if (core_rdata !== e_crd) begin bad++; $display("FAIL rnd_core_rdata cyc=%0d got=%h exp=%h", cyc, core_rdata, e_crd); end
            end
            if (chk_erd) begin
                total++; if (ext_rdata !== e_erd) begin bad++; $display("FAIL rnd_ext_rdata cyc=%0d got=%h exp=%h", cyc, ext_rdata, e_erd); end
            end
            core_done = !rst && core_ce && !e_stall;
            ext_done = !rst && e_ready;
            if (rst) begin
                owner = 0; last = 2;
            end else if (owner != 0) begin
                owner = 0;
            end else if (win != 0) begin
                last = win;
                if (e_we) begin
                    for (int b = 0; b < 4; b++)
                        if (e_sel[b]) ref_mem[e_addr[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
                end else begin
                    owner = win; rd_data = ref_mem[e_addr[5:2]];
                end
            end
            @(negedge clk);
        end
        rst = 1'b0; idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_core_store();
        test_core_load();
        test_contention_loads();
        test_ext_byte_store();
        test_reset_in_ext_rd();
        test_ext_starve();
        test_random();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
